// File: rtl/sram_responder_if.sv
// SRAM pin bus between an initiator (sram_driver) and a device (sram_responder).
//
// Bus protocol: sram_n_ce1 low selects the device. While selected, sram_n_write
// low marks a write; the address/data present on the last cycle both strobes are
// low is what gets written, and the write takes effect when either strobe rises.
// With sram_n_write high and sram_n_oe low the device may drive sram_data_out,
// and signals that it does by raising sram_data_oe.
interface sram_responder_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_data_in;
    logic              sram_n_write;
    logic              sram_n_ce1;
    logic              sram_n_oe;
    logic [DATA_W-1:0] sram_data_out;
    logic              sram_data_oe;

    modport master (
        output sram_address, sram_data_in, sram_n_write, sram_n_ce1, sram_n_oe,
        input  sram_data_out, sram_data_oe
    );

    modport slave (
        input  sram_address, sram_data_in, sram_n_write, sram_n_ce1, sram_n_oe,
        output sram_data_out, sram_data_oe
    );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: device end of the SRAM pin bus. Emulates NUM_REGS locations
// starting at BASE_ADDR, captures bus writes into a register file and reports
// each committed in-window write to the core with a one-cycle wr_valid pulse.
// Optional read path: define SRAM_RESPONDER_READ_EN to serve read cycles.
module sram_responder #(
    parameter int                ADDR_W      = 13,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 13'h1148,
    parameter int                NUM_REGS    = 6,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    sram_responder_if.slave            bus,
    output logic                       wr_valid,
    output logic [3:0]                 wr_index,
    output logic [DATA_W-1:0]          wr_data,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [1:0]                 dbg_state
);
    localparam int IN_W = ADDR_W + DATA_W + 3;
    // Strobes idle high so reset never looks like a selected bus.
    localparam logic [IN_W-1:0] SYNC_RST = {{(ADDR_W + DATA_W){1'b0}}, 3'b111};
    // One extra bit so a window ending at the top of the address space does not wrap.
    localparam logic [ADDR_W:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] LIMIT_EXT = BASE_EXT + (ADDR_W+1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, SELECTED, WRITING, COMMIT} state_t;

    logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q;
    logic [ADDR_W-1:0]  s_addr;
    logic [DATA_W-1:0]  s_data;
    logic               s_nwe, s_nce, s_noe;
    logic [ADDR_W-1:0]  cap_addr_q;
    logic [DATA_W-1:0]  cap_data_q;
    logic [3:0]         cap_idx;
    logic               cap_hit;
    state_t             state_q, state_d;
    logic               commit_fire, cap_load;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic               wr_valid_q;
    logic [3:0]         wr_index_q;
    logic [DATA_W-1:0]  wr_data_q;

    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] e;
        e = {1'b0, a};
        return (e >= BASE_EXT) && (e < LIMIT_EXT);
    endfunction

    assign s_noe  = sync_q[SYNC_STAGES-1][0];
    assign s_nce  = sync_q[SYNC_STAGES-1][1];
    assign s_nwe  = sync_q[SYNC_STAGES-1][2];
    assign s_data = sync_q[SYNC_STAGES-1][3 +: DATA_W];
    assign s_addr = sync_q[SYNC_STAGES-1][3+DATA_W +: ADDR_W];

    assign cap_hit = in_window(cap_addr_q);
    assign cap_idx = 4'(cap_addr_q - BASE_ADDR);

    // Bring every bus pin into the clk domain through SYNC_STAGES flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {bus.sram_address, bus.sram_data_in,
                          bus.sram_n_write, bus.sram_n_ce1, bus.sram_n_oe};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Track the last address/data seen while both strobes were low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_addr_q <= '0;
            cap_data_q <= '0;
        end else if (cap_load) begin
            cap_addr_q <= s_addr;
            cap_data_q <= s_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; a simultaneous rise of both strobes is one exit from WRITING.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!s_nce) state_d = s_nwe ? SELECTED : WRITING;
            SELECTED: begin
                if (s_nce)       state_d = IDLE;
                else if (!s_nwe) state_d = WRITING;
            end
            WRITING:  if (s_nwe || s_nce) state_d = COMMIT;
            COMMIT:   state_d = s_nce ? IDLE : SELECTED;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs: commit fires on the edge that enters COMMIT.
    always_comb begin
        cap_load    = !s_nce && !s_nwe;
        commit_fire = (state_q == WRITING) && (s_nwe || s_nce) && cap_hit;
    end

    // Register file and core notification, both updated on the commit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_valid_q <= 1'b0;
            wr_index_q <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_valid_q <= commit_fire;
            if (commit_fire) begin
                wr_index_q <= cap_idx;
                wr_data_q  <= cap_data_q;
                for (int i = 0; i < NUM_REGS; i++)
                    if (cap_idx == 4'(i)) regs_q[i] <= cap_data_q;
            end
        end
    end

    // Flatten the register file for the core.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
    end

    assign wr_valid  = wr_valid_q;
    assign wr_index  = wr_index_q;
    assign wr_data   = wr_data_q;
    assign dbg_state = state_q;

`ifdef SRAM_RESPONDER_READ_EN
    logic              oe_q, oe_d;
    logic [DATA_W-1:0] rd_q, rd_d;

    // Read decode; gated off in WRITING/COMMIT so the bus is never driven mid-write.
    always_comb begin
        oe_d = !s_nce && s_nwe && !s_noe && ((state_q == IDLE) || (state_q == SELECTED));
        rd_d = '1;
        if (in_window(s_addr)) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (4'(s_addr - BASE_ADDR) == 4'(i)) rd_d = regs_q[i];
        end
    end

    // Register the read data and its output enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oe_q <= 1'b0;
            rd_q <= '0;
        end else begin
            oe_q <= oe_d;
            rd_q <= rd_d;
        end
    end

    assign bus.sram_data_oe  = oe_q;
    assign bus.sram_data_out = rd_q;
`else
    logic unused_noe;
    assign unused_noe        = s_noe;
    assign bus.sram_data_oe  = 1'b0;
    assign bus.sram_data_out = '0;
`endif
endmodule
